// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain path: FIFO geometry, reader FSM
// encoding and a width helper used for counters and pointers.
package fifo_pkg;

  localparam int FIFO_DW    = 32;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
  } rd_state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read port plus downstream valid/ready stream for the FIFO reader.
// master = the reader, slave = the FIFO/consumer environment.
interface fifo_reader_if
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW
);
  logic          fifo_rd;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output fifo_rd,
    input  fifo_empty,
    input  fifo_dout,
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  fifo_rd,
    output fifo_empty,
    output fifo_dout,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fifo_reader_buf.sv
// Small circular holding buffer between FIFO read data and the output stream.
// Caller guarantees no push when full and no pop when empty.
module fifo_reader_buf
  import fifo_pkg::*;
#(
  parameter int  DW    = FIFO_DW,
  parameter int  DEPTH = 3,
  localparam int PW    = cnt_w(DEPTH),
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [OW-1:0] occ
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage is cleared too so the stream data reads as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains the synchronous FIFO into a valid/ready stream with out_last framing.
// state | meaning: IDLE = no reads (en=0 or FIFO empty) | FETCH = issuing reads | STALL = buffer credit exhausted
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DW        = FIFO_DW,
  parameter int BUF_DEPTH = 3,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  fifo_reader_if.master bus,
  output logic [15:0]   word_cnt,
  output logic          busy
);

  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int CW = OW + 1;
  localparam int BW = cnt_w(BURST_LEN);

  rd_state_e     state_q, state_d;
  logic          inflight_q, inflight_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [15:0]   word_cnt_q, word_cnt_d;

  logic [OW-1:0] occ;
  logic [DW-1:0] head_data;
  logic [CW-1:0] pending;
  logic          credit_ok, credit_full;
  logic          rd_w, valid_w, xfer;

  fifo_reader_buf #(
    .DW    (DW),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (bus.fifo_dout),
    .pop       (xfer),
    .head_data (head_data),
    .occ       (occ)
  );

  // Credit counts words already held plus the one still in flight, so the
  // read decision never has to look at out_ready.
  assign pending     = CW'(occ) + CW'(inflight_q);
  assign credit_ok   = pending < CW'(BUF_DEPTH);
  assign credit_full = pending == CW'(BUF_DEPTH);
  assign rd_w        = rst & en & ~bus.fifo_empty & credit_ok;
  assign valid_w     = (occ != '0);
  assign xfer        = valid_w & bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en || bus.fifo_empty) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_FETCH;
        ST_FETCH: if (credit_full) state_d = ST_STALL;
        ST_STALL: if (xfer) state_d = ST_FETCH;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    inflight_d = rd_w;
    beat_d     = beat_q;
    word_cnt_d = word_cnt_q;
    if (xfer) begin
      beat_d     = (beat_q == BW'(BURST_LEN - 1)) ? '0 : beat_q + 1'b1;
      word_cnt_d = word_cnt_q + 16'd1;
    end
  end

  always_comb begin
    bus.fifo_rd   = rd_w;
    bus.out_valid = valid_w;
    bus.out_data  = head_data;
    bus.out_last  = valid_w & (beat_q == BW'(BURST_LEN - 1));
    word_cnt      = word_cnt_q;
    busy          = valid_w | inflight_q;
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a FIFO model feeds the reader, a scoreboard
// monitor checks every accepted word and its out_last flag.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int DW = 32;
  localparam int BL = 4;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] word_cnt;
  logic        busy;

  fifo_reader_if #(.DW(DW)) bus ();

  fifo_reader #(
    .DW        (DW),
    .BUF_DEPTH (3),
    .BURST_LEN (BL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .word_cnt (word_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[$];
  exp_t          exp_q[$];
  int            exp_beat = 0;
  int            n_vec    = 0;
  int            n_miss   = 0;

  // FIFO model: data one cycle after fifo_rd, empty flag updates at the edge.
  always @(posedge clk) begin
    if (bus.fifo_rd && fq.size() > 0) bus.fifo_dout <= fq.pop_front();
    bus.fifo_empty <= (fq.size() == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] w);
    exp_t e;
    e.last   = (exp_beat == BL - 1);
    e.data   = w;
    exp_q.push_back(e);
    exp_beat = (exp_beat + 1) % BL;
  endtask

  task automatic fifo_load(input logic [DW-1:0] w);
    fq.push_back(w);
    push_exp(w);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fifo_rd"},   32'(bus.fifo_rd),   0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_data"},  bus.out_data,       0);
    check({tag, "_out_last"},  32'(bus.out_last),  0);
    check({tag, "_word_cnt"},  32'(word_cnt),      0);
    check({tag, "_busy"},      32'(busy),          0);
  endtask

  // Words buffered or in flight at reset are lost; expectation restarts
  // from whatever is still in the FIFO, at beat 0.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    exp_q.delete();
    exp_beat = 0;
    foreach (fq[i]) push_exp(fq[i]);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    while (!(!busy && (fq.size() == 0 || !en)) && k < max) begin
      @(negedge clk);
      k++;
    end
    if (k >= max) check({tag, "_idle_timeout"}, 32'(k), 32'(max - 1));
    check({tag, "_exp_left"}, 32'(exp_q.size()), 0);
  endtask

  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      if (bus.fifo_rd && bus.fifo_empty) check("rd_while_empty", 1, 0);
      if (hold_prev) begin
        check("hold_valid", 32'(bus.out_valid), 1);
        check("hold_data",  bus.out_data,       hold_data);
        check("hold_last",  32'(bus.out_last),  32'(hold_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", bus.out_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", bus.out_data,      e.data);
          check("sb_last", 32'(bus.out_last), 32'(e.last));
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
      hold_last = bus.out_last;
    end
  end

  logic [DW-1:0] t2_words [8] = '{100, 150, 10, 15, 1, 10, 16, 14};

  initial begin
    int rd_cnt;
    int k;
    int cyc;

    bus.out_ready = 1'b0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // Streaming at full rate
    bus.out_ready = 1'b1;
    foreach (t2_words[i]) fifo_load(t2_words[i]);
    repeat (2) @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    #1 check("t2_first_rd", 32'(bus.fifo_rd), 1);
    @(negedge clk);
    #1 check("t2_valid_n1", 32'(bus.out_valid), 0);
    @(negedge clk);
    #1 check("t2_valid_n2", 32'(bus.out_valid), 1);
    check("t2_data_n2", bus.out_data, 100);
    repeat (8) @(negedge clk);
    #1 check("t2_word_cnt", 32'(word_cnt), 8);
    wait_idle("t2", 50);

    // Back-pressure
    bus.out_ready = 1'b0;
    foreach (t2_words[i]) fifo_load(t2_words[i]);
    @(posedge clk);
    @(negedge clk);
    repeat (5) @(negedge clk);
    #1;
    check("t3_rd_stalled", 32'(bus.fifo_rd), 0);
    check("t3_head",       bus.out_data, 100);
    check("t3_valid",      32'(bus.out_valid), 1);
    check("t3_fifo_left",  32'(fq.size()), 5);
    check("t3_busy",       32'(busy), 1);
    bus.out_ready = 1'b1;
    wait_idle("t3", 50);
    check("t3_word_cnt", 32'(word_cnt), 16);

    // Single word, then empty
    fifo_load(250);
    rd_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      #1 if (bus.fifo_rd) rd_cnt++;
    end
    check("t4_rd_pulses", 32'(rd_cnt), 1);
    check("t4_busy",      32'(busy), 0);
    check("t4_valid",     32'(bus.out_valid), 0);
    check("t4_word_cnt",  32'(word_cnt), 17);

    // Reset with two words buffered and one in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) fifo_load(32'(1001 + i));
    @(posedge clk);
    @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    check("t1_busy",      32'(busy), 1);
    check("t1_head",      bus.out_data, 1001);
    check("t1_fifo_left", 32'(fq.size()), 4);
    check("t1_rd_full",   32'(bus.fifo_rd), 0);
    rst = 1'b0;
    #1;
    check_reset_outputs("t1_rst");
    exp_q.delete();
    exp_beat = 0;
    foreach (fq[i]) push_exp(fq[i]);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    wait_idle("t1", 50);
    check("t1_word_cnt", 32'(word_cnt), 4);

    // en dropped after the third read
    en = 1'b0;
    for (int i = 0; i < 6; i++) fifo_load(32'(31 + i));
    repeat (2) @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 en = 1'b0;
    rd_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      #1 if (bus.fifo_rd) rd_cnt++;
    end
    check("t5_rd_after_drop", 32'(rd_cnt), 0);
    check("t5_word_cnt",      32'(word_cnt), 7);
    check("t5_busy",          32'(busy), 0);
    check("t5_fifo_left",     32'(fq.size()), 3);
    check("t5_valid",         32'(bus.out_valid), 0);
    @(negedge clk);
    en = 1'b1;
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) break;
      k++;
    end
    check("t5_resume_valid", 32'(bus.out_valid), 1);
    check("t5_resume_data",  bus.out_data, 34);
    check("t5_resume_last",  32'(bus.out_last), 1);
    wait_idle("t5", 50);
    check("t5_word_cnt_end", 32'(word_cnt), 10);

    // Long stream: counter and pointer wraparound
    do_reset("t6_rst");
    for (int i = 0; i < 70000; i++) fifo_load(32'(i * 3 + 7));
    cyc = 0;
    while (!(!busy && fq.size() == 0) && cyc < 80000) begin
      @(negedge clk);
      bus.out_ready = (cyc % 16 != 5);
      cyc++;
    end
    if (cyc >= 80000) check("t6_timeout", 32'(cyc), 79999);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_word_cnt", 32'(word_cnt), 4464);
    check("t6_exp_left", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
